// File: rtl/xir_tx_pkg.sv
// xir_tx_pkg: register addresses, status bit positions and FSM encodings shared by the XIR transmitter
package xir_tx_pkg;
    localparam logic [1:0] XTX_DATA = 2'd0;
    localparam logic [1:0] XTX_CTRL = 2'd1;
    localparam logic [1:0] XTX_STAT = 2'd2;
    localparam logic [1:0] XTX_CARR = 2'd3;

    localparam int STAT_BUSY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_DONE = 3;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HMARK  = 3'd1;
    localparam logic [2:0] S_HSPACE = 3'd2;
    localparam logic [2:0] S_BMARK  = 3'd3;
    localparam logic [2:0] S_BSPACE = 3'd4;
    localparam logic [2:0] S_TMARK  = 3'd5;
    localparam logic [2:0] S_GAP    = 3'd6;

    function automatic logic isMark(input logic [2:0] s);
        return s == S_HMARK || s == S_BMARK || s == S_TMARK;
    endfunction
endpackage

// File: rtl/xir_carrier.sv
// xir_carrier: carrier phase generator for the IR LED, toggling every Div cycles while Run is high
//   Clk, Reset  clock, asynchronous active-low reset
//   Run         high while the transmitter is (about to be) in a mark state
//   Div         half-period in Clk cycles; 0 holds Phase at 1 (unmodulated)
//   Phase       registered carrier phase, 0 whenever Run is low
module xir_carrier (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic [15:0] Div,
    output logic        Phase
);
    logic [15:0] cnt;

    // Idle forces cnt=0/Phase=0, so the first running cycle reloads and raises Phase.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt   <= '0;
            Phase <= 1'b0;
        end else if (!Run) begin
            cnt   <= '0;
            Phase <= 1'b0;
        end else if (cnt == 16'd0) begin
            Phase <= (Div == 16'd0) | ~Phase;
            cnt   <= (Div == 16'd0) ? 16'd0 : Div - 16'd1;
        end else begin
            cnt <= cnt - 16'd1;
        end
    end
endmodule

// File: rtl/xir_tx.sv
// xir_tx: CPU-programmable IR message transmitter (header, pulse-distance bits LSB first, trailer, gap)
//   Clk, Reset                  clock, asynchronous active-low reset
//   Addr, DataWr, DataRd        register select, write data, combinational read data
//   En, Rd, Wr                  block select, read strobe, one-cycle write strobe
//   LedOut                      registered, carrier-modulated LED drive
//   IntStatus, IntReset         Done & IntEn, one-cycle pulse clearing Done
module xir_tx
    import xir_tx_pkg::*;
#(
    parameter int UNIT_CYC    = 30000,
    parameter int HDR_MARK_U  = 4,
    parameter int HDR_SPACE_U = 1,
    parameter int GAP_U       = 8,
    parameter int CARR_DEF    = 658
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  Addr,
    input  logic [15:0] DataWr,
    output logic [15:0] DataRd,
    input  logic        En,
    input  logic        Rd,
    input  logic        Wr,
    output logic        LedOut,
    output logic        IntStatus,
    input  logic        IntReset
);
    localparam int CW = $clog2(UNIT_CYC + 1);

    logic [2:0]    state, stateNext;
    logic [CW-1:0] cycCnt;
    logic [7:0]    unitCnt, unitLen;
    logic [15:0]   hold, shift, carrDiv, rdStat;
    logic [4:0]    nBits, bitCnt;
    logic          txEn, intEn, full, ovr, done;
    logic          busy, unitEnd, stateEnd, load, wrData, wrCtrl, wrStat, wrCarr, accept;

    assign busy    = state != S_IDLE;
    assign wrData  = En & Wr & (Addr == XTX_DATA);
    assign wrCtrl  = En & Wr & (Addr == XTX_CTRL);
    assign wrStat  = En & Wr & (Addr == XTX_STAT);
    assign wrCarr  = En & Wr & (Addr == XTX_CARR);
    assign unitLen = state == S_HMARK  ? 8'(HDR_MARK_U)  :
                     state == S_HSPACE ? 8'(HDR_SPACE_U) :
                     state == S_GAP    ? 8'(GAP_U)       :
                     (state == S_BSPACE && shift[0]) ? 8'd3 : 8'd1;
    assign unitEnd  = cycCnt == CW'(UNIT_CYC - 1);
    assign stateEnd = busy & unitEnd & (unitCnt == unitLen - 8'd1);
    // A frame starts from IDLE, or back-to-back straight out of the gap.
    assign load     = txEn & full & (!busy | (state == S_GAP & stateEnd));
    // Hold frees up on the same edge it moves to Shift, so a write then is accepted.
    assign accept   = wrData & (!full | load);
    assign IntStatus = done & intEn;

    always_comb begin
        stateNext = state;
        if (load) stateNext = S_HMARK;
        else if (stateEnd)
            case (state)
                S_HMARK:  stateNext = S_HSPACE;
                S_HSPACE: stateNext = S_BMARK;
                S_BMARK:  stateNext = S_BSPACE;
                S_BSPACE: stateNext = bitCnt == 5'd1 ? S_TMARK : S_BMARK;
                S_TMARK:  stateNext = S_GAP;
                default:  stateNext = S_IDLE;
            endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IDLE;
            cycCnt  <= '0;
            unitCnt <= '0;
            shift   <= '0;
            bitCnt  <= '0;
        end else begin
            state   <= stateNext;
            cycCnt  <= (load | stateEnd | unitEnd | !busy) ? '0 : cycCnt + CW'(1);
            unitCnt <= (load | stateEnd | !busy) ? '0 : unitCnt + 8'(unitEnd);
            if (load) begin
                shift  <= hold;
                bitCnt <= nBits == 5'd0 ? 5'd16 : nBits;
            end else if (stateEnd && state == S_BSPACE) begin
                shift  <= shift >> 1;
                bitCnt <= bitCnt - 5'd1;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hold    <= '0;
            full    <= 1'b0;
            ovr     <= 1'b0;
            done    <= 1'b0;
            nBits   <= '0;
            txEn    <= 1'b0;
            intEn   <= 1'b0;
            carrDiv <= 16'(CARR_DEF);
        end else begin
            if (accept) hold <= DataWr;
            full <= accept | (full & !load);
            // Set beats clear when both land on the same edge.
            ovr  <= (wrData & full & !load) | (ovr & !(wrStat & DataWr[STAT_OVR]));
            done <= (state == S_GAP & stateEnd) | (done & !(IntReset | (wrStat & DataWr[STAT_DONE])));
            if (wrCtrl) begin
                nBits <= DataWr[4:0];
                txEn  <= DataWr[8];
                intEn <= DataWr[9];
            end
            if (wrCarr) carrDiv <= DataWr;
        end
    end

    // The carrier follows the next state so LedOut is already driven in the first mark cycle.
    xir_carrier carrier (
        .Clk  (Clk),
        .Reset(Reset),
        .Run  (isMark(stateNext)),
        .Div  (carrDiv),
        .Phase(LedOut)
    );

    always_comb begin
        rdStat = '0;
        rdStat[STAT_BUSY] = busy;
        rdStat[STAT_FULL] = full;
        rdStat[STAT_OVR]  = ovr;
        rdStat[STAT_DONE] = done;
    end

    assign DataRd = !(En & Rd)         ? 16'd0 :
                    Addr == XTX_DATA   ? hold  :
                    Addr == XTX_CTRL   ? {6'd0, intEn, txEn, 3'd0, nBits} :
                    Addr == XTX_STAT   ? rdStat : carrDiv;
endmodule
